// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and constants for the microwave keypad entry path.
package oven_pkg;

  localparam int BCD_W      = 4;
  localparam int KEYS       = 10;
  localparam int MAX_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // True when exactly one key line is active: clearing the lowest set bit leaves nothing.
  function automatic logic is_onehot10(input logic [KEYS-1:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: raw keys and control in, BCD time buffer and strobes out.
interface keypad_entry_ctrl_if;
  import oven_pkg::*;

  logic [KEYS-1:0]  keypad;
  logic             clear;
  logic             lock;
  logic [BCD_W-1:0] min_tens;
  logic [BCD_W-1:0] min_ones;
  logic [BCD_W-1:0] sec_tens;
  logic [BCD_W-1:0] sec_ones;
  logic [BCD_W-1:0] key_bcd;
  logic             digit_stb;
  logic             reject_stb;
  logic [2:0]       digit_count;
  logic             entry_valid;

  // Front panel / timer side.
  modport master (
    output keypad, clear, lock,
    input  min_tens, min_ones, sec_tens, sec_ones, key_bcd,
           digit_stb, reject_stb, digit_count, entry_valid
  );

  // Entry controller side.
  modport slave (
    input  keypad, clear, lock,
    output min_tens, min_ones, sec_tens, sec_ones, key_bcd,
           digit_stb, reject_stb, digit_count, entry_valid
  );

endinterface

// File: rtl/keypad_entry_ctrl_enc.sv
// One-hot key pattern to BCD digit; anything not exactly one-hot encodes as 0.
module key_onehot_to_bcd
  import oven_pkg::*;
(
  input  logic [KEYS-1:0]  onehot,
  output logic [BCD_W-1:0] bcd
);

  // Table lookup so multi-bit or empty patterns fall through to 0.
  always_comb begin
    bcd = 4'd0;
    case (onehot)
      10'b00_0000_0001: bcd = 4'd0;
      10'b00_0000_0010: bcd = 4'd1;
      10'b00_0000_0100: bcd = 4'd2;
      10'b00_0000_1000: bcd = 4'd3;
      10'b00_0001_0000: bcd = 4'd4;
      10'b00_0010_0000: bcd = 4'd5;
      10'b00_0100_0000: bcd = 4'd6;
      10'b00_1000_0000: bcd = 4'd7;
      10'b01_0000_0000: bcd = 4'd8;
      10'b10_0000_0000: bcd = 4'd9;
      default:          bcd = 4'd0;
    endcase
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces single-key presses and shifts the BCD
// digits right-to-left into an MM:SS cook-time buffer.
module keypad_entry_ctrl
  import oven_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] DIGIT_MAX = 3'(MAX_DIGITS);

  state_t           state_r;
  logic [KEYS-1:0]  latch_r;
  logic [7:0]       cnt_r;
  logic [BCD_W-1:0] min_tens_r;
  logic [BCD_W-1:0] min_ones_r;
  logic [BCD_W-1:0] sec_tens_r;
  logic [BCD_W-1:0] sec_ones_r;
  logic [BCD_W-1:0] key_bcd_r;
  logic             digit_stb_r;
  logic             reject_stb_r;
  logic [2:0]       digit_count_r;
  logic             entry_valid_r;
  logic [BCD_W-1:0] enc_bcd_s;

  // The encoder always looks at the latched pattern, so the key may already
  // be released by the time the capture happens.
  key_onehot_to_bcd u_enc (
    .onehot (latch_r),
    .bcd    (enc_bcd_s)
  );

  // Entry FSM, debounce counter and digit shift buffer; clear beats lock beats normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      latch_r       <= 10'd0;
      cnt_r         <= 8'd0;
      min_tens_r    <= 4'd0;
      min_ones_r    <= 4'd0;
      sec_tens_r    <= 4'd0;
      sec_ones_r    <= 4'd0;
      key_bcd_r     <= 4'd0;
      digit_stb_r   <= 1'b0;
      reject_stb_r  <= 1'b0;
      digit_count_r <= 3'd0;
      entry_valid_r <= 1'b0;
    end else begin
      digit_stb_r  <= 1'b0;
      reject_stb_r <= 1'b0;
      if (bus.clear) begin
        min_tens_r    <= 4'd0;
        min_ones_r    <= 4'd0;
        sec_tens_r    <= 4'd0;
        sec_ones_r    <= 4'd0;
        key_bcd_r     <= 4'd0;
        digit_count_r <= 3'd0;
        entry_valid_r <= 1'b0;
        state_r       <= bus.lock ? WAIT_RELEASE : IDLE;
      end else if (bus.lock) begin
        // Running oven: freeze entry and demand a fresh press afterwards.
        state_r <= WAIT_RELEASE;
      end else begin
        case (state_r)
          IDLE: begin
            if (is_onehot10(bus.keypad)) begin
              latch_r <= bus.keypad;
              cnt_r   <= 8'd0;
              state_r <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (bus.keypad == latch_r) begin
              cnt_r <= cnt_r + 8'd1;
              if (cnt_r == CNT_LAST) begin
                state_r <= CAPTURE;
              end
            end else begin
              // Release, bounce or a second key: abandon this press.
              state_r <= IDLE;
            end
          end
          CAPTURE: begin
            key_bcd_r <= enc_bcd_s;
            if (digit_count_r < DIGIT_MAX) begin
              min_tens_r    <= min_ones_r;
              min_ones_r    <= sec_tens_r;
              sec_tens_r    <= sec_ones_r;
              sec_ones_r    <= enc_bcd_s;
              digit_count_r <= digit_count_r + 3'd1;
              entry_valid_r <= 1'b1;
              digit_stb_r   <= 1'b1;
            end else begin
              reject_stb_r <= 1'b1;
            end
            state_r <= WAIT_RELEASE;
          end
          WAIT_RELEASE: begin
            if (bus.keypad == 10'd0) begin
              state_r <= IDLE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign bus.min_tens    = min_tens_r;
  assign bus.min_ones    = min_ones_r;
  assign bus.sec_tens    = sec_tens_r;
  assign bus.sec_ones    = sec_ones_r;
  assign bus.key_bcd     = key_bcd_r;
  assign bus.digit_stb   = digit_stb_r;
  assign bus.reject_stb  = reject_stb_r;
  assign bus.digit_count = digit_count_r;
  assign bus.entry_valid = entry_valid_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed key sequences checked every cycle
// against a press-history model, plus hand-computed spot values.
module tb_keypad_entry_ctrl;
  import oven_pkg::*;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;

  keypad_entry_ctrl_if bus();

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int stb_cnt  = 0;
  int rej_cnt  = 0;
  int stb_cyc  = -1;
  bit chk_en   = 1'b0;

  // Model: entered digits kept as a list; display digits are its last four.
  int         m_digits[$];
  int         m_key  = 0;
  bit         m_dstb = 1'b0;
  bit         m_rstb = 1'b0;
  bit         m_wait = 1'b0;   // a key must be seen released before a new press counts
  int         m_run  = 0;      // identical one-hot samples seen so far in this press
  logic [9:0] m_pat  = 10'd0;
  bit         m_due  = 1'b0;   // enough stable samples: digit is taken on the next edge

  function automatic int key_value(input logic [9:0] v);
    for (int i = 0; i < 10; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic int exp_digit(input int pos);
    if (m_digits.size() > pos) return m_digits[m_digits.size() - 1 - pos];
    return 0;
  endfunction

  task automatic model_step(input logic [9:0] kp, input bit rs, input bit clr, input bit lk);
    m_dstb = 1'b0;
    m_rstb = 1'b0;
    if (rs) begin
      m_digits.delete();
      m_key = 0; m_wait = 1'b0; m_run = 0; m_due = 1'b0;
    end else if (clr || lk) begin
      if (clr) begin
        m_digits.delete();
        m_key = 0;
      end
      m_due  = 1'b0;
      m_run  = 0;
      m_wait = lk;
    end else if (m_due) begin
      m_due  = 1'b0;
      m_wait = 1'b1;
      m_key  = key_value(m_pat);
      if (m_digits.size() < MAX_DIGITS) begin
        m_digits.push_back(m_key);
        m_dstb = 1'b1;
      end else begin
        m_rstb = 1'b1;
      end
    end else if (m_wait) begin
      if (kp == 10'd0) m_wait = 1'b0;
    end else if (m_run > 0) begin
      if (kp == m_pat) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_due = 1'b1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if ($countones(kp) == 1) begin
      m_pat = kp;
      m_run = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] kp, input bit clr = 1'b0, input bit lk = 1'b0);
    bus.keypad = kp;
    bus.clear  = clr;
    bus.lock   = lk;
    model_step(kp, reset, clr, lk);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [9:0] kp, input int n, input bit clr = 1'b0, input bit lk = 1'b0);
    for (int i = 0; i < n; i++) step(kp, clr, lk);
  endtask

  // Cycle-by-cycle comparison of every output against the model, plus strobe bookkeeping.
  always @(negedge clk) begin
    if (chk_en) begin
      check("min_tens",    int'(bus.min_tens),    exp_digit(3));
      check("min_ones",    int'(bus.min_ones),    exp_digit(2));
      check("sec_tens",    int'(bus.sec_tens),    exp_digit(1));
      check("sec_ones",    int'(bus.sec_ones),    exp_digit(0));
      check("key_bcd",     int'(bus.key_bcd),     m_key);
      check("digit_stb",   int'(bus.digit_stb),   int'(m_dstb));
      check("reject_stb",  int'(bus.reject_stb),  int'(m_rstb));
      check("digit_count", int'(bus.digit_count), m_digits.size());
      check("entry_valid", int'(bus.entry_valid), int'(m_digits.size() != 0));
      if (bus.digit_stb) begin
        stb_cnt++;
        stb_cyc = cyc;
      end
      if (bus.reject_stb) rej_cnt++;
    end
  end

  initial begin
    int keys[4] = '{1, 2, 3, 0};

    // Reset held two cycles with key 5 down.
    reset  = 1'b1;
    chk_en = 1'b1;
    hold(10'h020, 2);
    check("rst_sec_ones",    int'(bus.sec_ones), 0);
    check("rst_digit_count", int'(bus.digit_count), 0);
    check("rst_entry_valid", int'(bus.entry_valid), 0);
    check("rst_digit_stb",   int'(bus.digit_stb), 0);

    // Single key 5 held 20 cycles from cycle 0.
    reset   = 1'b0;
    cyc     = 0;
    stb_cnt = 0;
    stb_cyc = -1;
    hold(10'h020, 20);
    check("single_stb_cycle", stb_cyc, 6);
    check("single_stb_count", stb_cnt, 1);
    check("single_sec_ones",  int'(bus.sec_ones), 5);
    check("single_key_bcd",   int'(bus.key_bcd), 5);
    check("single_count",     int'(bus.digit_count), 1);
    check("single_valid",     int'(bus.entry_valid), 1);

    // Full entry 1,2,3,0 then a rejected fifth key 9.
    hold(10'h000, 2);
    step(10'h000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      hold(10'd1 << keys[i], 8);
      hold(10'h000, 2);
    end
    check("full_min_tens", int'(bus.min_tens), 1);
    check("full_min_ones", int'(bus.min_ones), 2);
    check("full_sec_tens", int'(bus.sec_tens), 3);
    check("full_sec_ones", int'(bus.sec_ones), 0);
    check("full_count",    int'(bus.digit_count), 4);
    rej_cnt = 0;
    stb_cnt = 0;
    hold(10'h200, 8);
    hold(10'h000, 2);
    check("reject_count",    rej_cnt, 1);
    check("reject_no_digit", stb_cnt, 0);
    check("reject_key_bcd",  int'(bus.key_bcd), 9);
    check("reject_min_tens", int'(bus.min_tens), 1);
    check("reject_sec_ones", int'(bus.sec_ones), 0);
    check("reject_count4",   int'(bus.digit_count), 4);

    // Invalid presses on an empty buffer.
    step(10'h000, 1'b1);
    stb_cnt = 0;
    hold(10'h080, 2);
    hold(10'h000, 1);
    hold(10'h080, 2);
    hold(10'h000, 3);
    check("bounce_no_stb", stb_cnt, 0);
    stb_cnt = 0;
    hold(10'h003, 10);
    hold(10'h000, 2);
    check("multikey_no_stb", stb_cnt, 0);
    stb_cnt = 0;
    hold(10'h010, 2);
    hold(10'h050, 4);
    hold(10'h000, 2);
    check("second_key_no_stb", stb_cnt, 0);

    // Clear in the capture cycle of key 2 after entering 8.
    hold(10'h100, 8);
    hold(10'h000, 2);
    check("clear_pre_sec_ones", int'(bus.sec_ones), 8);
    stb_cnt = 0;
    hold(10'h004, 5);
    step(10'h004, 1'b1);
    hold(10'h000, 2);
    check("clear_no_stb",   stb_cnt, 0);
    check("clear_sec_ones", int'(bus.sec_ones), 0);
    check("clear_count",    int'(bus.digit_count), 0);
    check("clear_valid",    int'(bus.entry_valid), 0);

    // Lock with key 3 held, drop lock while held, then release and re-press.
    stb_cnt = 0;
    hold(10'h008, 10, 1'b0, 1'b1);
    hold(10'h008, 10);
    check("lock_no_stb", stb_cnt, 0);
    hold(10'h000, 2);
    hold(10'h008, 8);
    hold(10'h000, 2);
    check("lock_sec_ones", int'(bus.sec_ones), 3);
    check("lock_count",    int'(bus.digit_count), 1);
    check("lock_stb",      stb_cnt, 1);

    // Clear and lock together, key 5 held: buffer cleared, press ignored until released.
    stb_cnt = 0;
    step(10'h020, 1'b1, 1'b1);
    hold(10'h020, 8);
    hold(10'h000, 2);
    check("clrlock_count",  int'(bus.digit_count), 0);
    check("clrlock_no_stb", stb_cnt, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Sequences the microwave front-panel keypad into a 4-digit cook-time entry (MM:SS, BCD).
- Samples the raw one-hot 10-key bus, debounces it and qualifies exactly-one-key presses.
- Converts each accepted key to BCD through the one-hot-to-BCD encoder.
- Shifts the digit into a right-entry time buffer that feeds the countdown timer and 7-segment display path.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples required before a key is accepted (legal range 1..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
keypad  input  10  raw key lines, bit n high = key n pressed
clear  input  1  synchronous clear of entry buffer (CANCEL key)
lock  input  1  high while oven is running; entry frozen
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit
sec_ones  output  4  BCD seconds ones digit
key_bcd  output  4  BCD value of last accepted key
digit_stb  output  1  one-cycle pulse: digit shifted into buffer
reject_stb  output  1  one-cycle pulse: key accepted but buffer full, digit dropped
digit_count  output  3  number of digits entered, 0..4
entry_valid  output  1  high when digit_count != 0

Behaviour:
- Reset has priority over every other input.
  - On reset, all outputs go to 0, the state goes to IDLE, and the internal latch and counter go to 0.
- All outputs are registered.
- A valid press is defined as keypad having exactly one bit set. The values 0 and multi-bit patterns are never valid.
- State machine. IDLE, DEBOUNCE, CAPTURE and WAIT_RELEASE are evaluated in this priority order: reset, clear, lock, normal transitions.
  - IDLE: on a valid press, latch the pattern, clear cnt and go to DEBOUNCE.
  - DEBOUNCE: if keypad equals the latched pattern, increment cnt. When the match occurs with cnt == DEBOUNCE_CYCLES-1, go to CAPTURE. On any mismatch (release, bounce, second key), return to IDLE with no capture.
  - CAPTURE (exactly 1 cycle): encode the latched pattern and set key_bcd from it.
    - If digit_count < 4: shift min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=new digit. Increment digit_count and assert digit_stb.
    - Otherwise: leave the buffer and count unchanged and assert reject_stb.
    - Then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until keypad == 0, then go to IDLE. A held key therefore produces exactly one capture.
- Latency: a press first sampled valid in IDLE at cycle t, and stable thereafter, gives CAPTURE at t+DEBOUNCE_CYCLES+1. The buffer update and strobe are visible at t+DEBOUNCE_CYCLES+2.
  - The key is not required to still be held during the CAPTURE cycle.
- clear:
  - Zeroes the four digits, digit_count, key_bcd and both strobes in the next cycle, and forces the state to IDLE.
  - A capture scheduled in the same cycle is discarded.
- lock:
  - Forces the state to WAIT_RELEASE and holds the buffer.
  - A capture in the same cycle is discarded.
  - After lock falls, a key still held must be released and re-pressed.
- clear and lock together: the buffer is cleared and the state goes to WAIT_RELEASE.
- Buffer digits are always 0..9 (encoder output). digit_count saturates at 4 and never wraps.
- digit_stb and reject_stb are mutually exclusive and never assert two consecutive cycles.

Decomposition:
- Shared package oven_pkg holds:
  - the state enum (IDLE, DEBOUNCE, CAPTURE, WAIT_RELEASE);
  - BCD_W = 4, KEYS = 10, MAX_DIGITS = 4;
  - a function is_onehot10.
- One combinational sub-module, key_onehot_to_bcd: 10-bit one-hot in, 4-bit BCD out, 0 for non-one-hot input. It is instantiated once on the latched pattern.
- Counter, FSM and shift buffer stay in keypad_entry_ctrl.

Test Plan:
- Reset: assert reset 2 cycles with keypad=0x020 -> all outputs 0; after release, no capture until DEBOUNCE_CYCLES stable samples.
- Single key (DEBOUNCE_CYCLES=4): keypad=0x020 from cycle 0, held 20 cycles -> digit_stb only at cycle 6; sec_ones=5, key_bcd=5, digit_count=1, entry_valid=1; exactly one strobe.
- Full entry: keys 1,2,3,0 with releases between -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0, digit_count=4. Fifth key 9 -> reject_stb pulse, key_bcd=9, buffer unchanged.
- Invalid presses:
  - Key 7 pressed 2 cycles, released 1 cycle, pressed 2 cycles -> no strobe.
  - keypad=0x003 held 10 cycles -> no strobe.
  - Key 4 pressed, then key 6 added during DEBOUNCE -> no strobe.
- clear: enter 8, then press key 2 and assert clear in its CAPTURE cycle -> all digits 0, digit_count=0, no digit_stb.
- lock: key 3 held while lock=1 -> no capture. Lock drops with key still held -> no capture. Release then re-press -> sec_ones=3.
